// File: rtl/sipo_collector.sv
// Serial-to-parallel collector: assembles LSB-first serial bits into WIDTH-bit words
// behind a double-buffered valid/ready output. Optional parity via SIPO_PARITY_CHECK_EN.
module sipo_collector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             clr_err
`ifdef SIPO_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
    logic               par_err_q, par_err_d;
    logic               parity_bad;
`endif

    logic [WIDTH-1:0]   word_next;
    logic [WIDTH-1:0]   offer_word;
    logic               offer;
    logic               drop;
    logic               last_bit;

    assign word_next = {ser_in, sr_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        offer      = 1'b0;
        offer_word = word_next;
`ifdef SIPO_PARITY_CHECK_EN
        parity_bad = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ser_valid) begin
                    sr_d    = word_next;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    sr_d = word_next;
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef SIPO_PARITY_CHECK_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        offer   = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            // The completed word waits in sr_q until its even-parity bit arrives.
            PAR: begin
                if (ser_valid) begin
                    state_d    = IDLE;
                    offer      = 1'b1;
                    offer_word = sr_q;
                    parity_bad = ((^sr_q) != ser_in);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop        = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A new word replaces the held one only if the slot is empty or being popped now.
        if (offer) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = offer_word;
                out_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        overrun_d = overrun_q;
        if (clr_err) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end

`ifdef SIPO_PARITY_CHECK_EN
        par_err_d = par_err_q;
        if (clr_err) begin
            par_err_d = 1'b0;
        end
        if (offer && parity_bad) begin
            par_err_d = 1'b1;
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            // NOTE: the assembly register is a plain register, not a memory, so it is
            // cheap to reset and guarantees no residue from a discarded word.
            sr_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign bit_cnt   = cnt_q;
    assign busy      = (cnt_q != '0);
    assign overrun   = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
    assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: directed scenarios plus random traffic checked against
// a word-level model (bit accumulator + single-slot output buffer).
module tb_sipo_collector;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_CHECK_EN
    localparam int WORD_BITS = WIDTH + 1;
`else
    localparam int WORD_BITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             clr_err = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    logic             parity_err;
`endif

    sipo_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun),
        .clr_err   (clr_err)
`ifdef SIPO_PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bits accumulate arithmetically into m_acc at position m_n.
    int               m_n    = 0;
    int unsigned      m_acc  = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit               m_valid = 1'b0;
    bit               m_over  = 1'b0;
    bit               m_perr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit sv, input bit si, input bit rdy, input bit clr);
        bit               done = 1'b0;
        bit               drop = 1'b0;
        bit               pbad = 1'b0;
        logic [WIDTH-1:0] w = '0;
        if (r) begin
            m_n = 0; m_acc = 0; m_data = '0; m_valid = 0; m_over = 0; m_perr = 0;
            return;
        end
        if (sv) begin
            m_acc = m_acc | (32'(si) << m_n);
            m_n++;
            if (m_n == WORD_BITS) begin
                done = 1'b1;
                w    = m_acc[WIDTH-1:0];
`ifdef SIPO_PARITY_CHECK_EN
                pbad = ((^w) != m_acc[WIDTH]);
`endif
                m_acc = 0;
                m_n   = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (clr) begin
            m_over = 1'b0;
            m_perr = 1'b0;
        end
        if (drop) m_over = 1'b1;
        if (done && pbad) m_perr = 1'b1;
    endtask

    task automatic compare_all();
        int exp_cnt;
        exp_cnt = (m_n >= WIDTH) ? 0 : m_n;
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("bit_cnt", 32'(bit_cnt), 32'(exp_cnt));
        check("busy", 32'(busy), 32'(exp_cnt != 0));
        check("overrun", 32'(overrun), 32'(m_over));
`ifdef SIPO_PARITY_CHECK_EN
        check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    endtask

    // Inputs change 1ns after the edge; outputs are sampled at the same point.
    task automatic step(input bit sv, input bit si, input bit rdy, input bit clr, input bit r = 1'b0);
        ser_valid = sv;
        ser_in    = si;
        out_ready = rdy;
        clr_err   = clr;
        rst       = r;
        @(posedge clk);
        model_edge(r, sv, si, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, bits[i], rdy, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_cnt", 32'(bit_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

`ifndef SIPO_PARITY_CHECK_EN
        // Basic word 1,0,1,1 -> 4'hD.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_cnt1", 32'(bit_cnt), 32'd1);
        check("t1_busy1", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t1_cnt2", 32'(bit_cnt), 32'd2);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_cnt3", 32'(bit_cnt), 32'd3);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_cnt0", 32'(bit_cnt), 32'd0);
        check("t1_busy0", 32'(busy), 32'd0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'hD);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_pulse", 32'(out_valid), 32'd0);
        check("t1_hold_data", 32'(out_data), 32'hD);

        // Gap of three idle cycles after bit 2.
        send_bits(8'b0000_0001, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("t2_gap_cnt", 32'(bit_cnt), 32'd2);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_data", 32'(out_data), 32'hD);
        check("t2_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: 4'h3 then 4'hA with the sink stalled.
        send_bits(8'h3, 4, 1'b0);
        check("t3_first", 32'(out_data), 32'h3);
        send_bits(8'hA, 4, 1'b0);
        check("t3_keep", 32'(out_data), 32'h3);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_still_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_clr", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_pop", 32'(out_valid), 32'd0);
        check("t3_pop_data", 32'(out_data), 32'h3);

        // Pop and load on the same edge: hold 4'h5, complete 4'h9 with out_ready.
        send_bits(8'h5, 4, 1'b0);
        check("t4_hold", 32'(out_data), 32'h5);
        send_bits(8'h9, 3, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_data", 32'(out_data), 32'h9);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word discards the partial bits.
        send_bits(8'h3, 2, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_rst_cnt", 32'(bit_cnt), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'h0);
        send_bits(8'h6, 4, 1'b1);
        check("t5_data", 32'(out_data), 32'h6);
        check("t5_valid", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
`else
        // Data 1,0,1,1 with correct then wrong even-parity bit.
        send_bits(8'b1_1101, 5, 1'b1);
        check("t6_data_ok", 32'(out_data), 32'hD);
        check("t6_perr0", 32'(parity_err), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(8'b0_1101, 5, 1'b1);
        check("t6_data_bad", 32'(out_data), 32'hD);
        check("t6_perr1", 32'(parity_err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_perr_clr", 32'(parity_err), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sipo_collector.md
Name: sipo_collector

Overview:
- Downstream consumer of the 4-bit universal shift register's serial output `q`.
- Samples `q` one bit per qualified cycle, LSB first, matching the right-shift order.
- Assembles WIDTH-bit words and presents them on a valid/ready parallel interface.
- Double-buffered: the next word assembles while the previous one waits for the sink. Drops are flagged with a sticky overrun.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data; connects to shift register `q`.
- ser_valid  input  1  qualifies ser_in; high on each cycle the shifter presents a new bit.
- out_data  output  WIDTH  assembled word; bit 0 is the first bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  sink accepts out_data when out_valid && out_ready.
- busy  output  1  a partial word is in the assembly register (bit_cnt != 0).
- bit_cnt  output  CNT_W  bits collected in the current word.
- overrun  output  1  sticky; a completed word was dropped.
- clr_err  input  1  clears overrun (and parity_err when enabled).

Behaviour:
- Interface decision: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, busy=0, bit_cnt=0, overrun=0, parity_err=0, FSM=IDLE, assembly register=0.
- Reset mid-word discards the partial word. Reset while out_valid=1 discards the held word.
- FSM states: IDLE, SHIFT, and PAR (PAR exists only with the optional feature).
  - IDLE: bit_cnt=0. Goes to SHIFT on ser_valid.
  - SHIFT: each ser_valid does sr <= {ser_in, sr[WIDTH-1:1]} and bit_cnt+1.
  - ser_valid=0 in SHIFT holds state. Gaps of any length are allowed; there is no timeout.
- Word completion: the ser_valid cycle where bit_cnt==WIDTH-1.
  - On that edge, bit_cnt returns to 0 and the FSM returns to IDLE (or goes to PAR).
  - The completed word is {ser_in, sr[WIDTH-1:1]}. It is offered to the output register on the same edge.
- Output register load rules at a completion edge:
  - out_valid=0: load; out_valid=1 on the following cycle. Latency is 1 cycle from the last bit's edge.
  - out_valid=1 and out_ready=1 on the same cycle: pop the old word and load the new one; out_valid stays 1.
  - out_valid=1 and out_ready=0: drop the new word, keep out_data unchanged, set overrun=1.
- Pop without completion: out_valid && out_ready clears out_valid on the next edge. out_data retains its last value.
- Back-to-back words with ser_valid held high: one bit per cycle, with no dead cycle between words.
- overrun priority: a new drop in the same cycle as clr_err leaves overrun=1 (set wins over clear).
- out_data and out_valid are stable while out_valid && !out_ready.
- bit_cnt counts 0..WIDTH-1 only and never reaches WIDTH.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Adds output `parity_err` (output 1, sticky, cleared by clr_err or rst).
  - After the WIDTH-th bit, the FSM enters PAR. The next ser_valid bit is the parity bit.
  - Expected parity is even: XOR of data bits == parity bit.
  - The word is offered to the output register on the parity-bit edge, not on the data-bit edge. Latency is 1 cycle from the parity edge.
  - On mismatch, the word is still delivered and parity_err=1.
- Not defined: no PAR state, no parity_err port. A word is exactly WIDTH bits.

Test Plan:
1. After rst, drive ser_valid=1 with ser_in 1,0,1,1 on 4 consecutive cycles, out_ready=1 -> out_data=4'hD, out_valid=1 one cycle after the 4th bit, pulse lasts 1 cycle, busy=1 during bits 2-4 and bit_cnt goes 1,2,3,0.
2. Same bits with a 3-cycle ser_valid=0 gap after bit 2 -> out_data=4'hD; bit_cnt holds at 2 during the gap.
3. out_ready=0: send 4'h3 then 4'hA back-to-back -> out_data stays 4'h3, overrun=1. Pulse clr_err -> overrun=0. Assert out_ready -> out_valid=0 next cycle.
4. Hold out_valid=1 with 4'h5, assert out_ready on the exact completion cycle of 4'h9 -> out_data=4'h9, out_valid stays 1, overrun=0.
5. Send 2 bits, assert rst for 1 cycle, then send 0,1,1,0 -> out_data=4'h6, with no residue from the discarded bits.
6. With SIPO_PARITY_CHECK_EN: send 1,0,1,1 then parity 1 -> out_data=4'hD, parity_err=0. Send 1,0,1,1 then parity 0 -> out_data=4'hD, parity_err=1.
